// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: takes 16 block words and emits W_0..W_{N-1}, one per handshake.
// Build option SHA2_MSCHED_SHA512_EN enables the 64-bit SHA-512 datapath; otherwise SHA-256 only.
module sha2_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode64,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic [6:0]  m_round,
    output logic        m_last
);

`ifdef SHA2_MSCHED_SHA512_EN
    localparam int WW = 64;
`else
    localparam int WW = 32;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] win [16];
    logic [WW-1:0] data_q;
    logic [6:0]    t, round_q, t_last;
    logic          valid_q, last_q, m;
    logic          free, accept, expand_go;
    logic [WW-1:0] word_in, sum, w_new, nxt_word;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [63:0] sig0(input logic [63:0] x, input logic md);
        logic [31:0] lo;
        lo = rotr32(x[31:0], 7) ^ rotr32(x[31:0], 18) ^ (x[31:0] >> 3);
        if (md) return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
        return {32'd0, lo};
    endfunction

    function automatic logic [63:0] sig1(input logic [63:0] x, input logic md);
        logic [31:0] lo;
        lo = rotr32(x[31:0], 17) ^ rotr32(x[31:0], 19) ^ (x[31:0] >> 10);
        if (md) return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
        return {32'd0, lo};
    endfunction

`ifdef SHA2_MSCHED_SHA512_EN
    logic m_q;
    logic mode_in;

    assign m       = m_q;
    // The mode for W_0 comes straight from the port; later words use the latched copy.
    assign mode_in = (state == IDLE) ? mode64 : m_q;
    assign word_in = mode_in ? s_data : {32'd0, s_data[31:0]};
    assign w_new   = m ? sum : {32'd0, sum[31:0]};
    assign m_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_q <= 1'b0;
        else if (accept && state == IDLE)
            m_q <= mode64;
    end
`else
    logic unused_in;

    assign m         = 1'b0;
    assign word_in   = s_data[31:0];
    assign w_new     = sum;
    assign m_data    = {32'd0, data_q};
    assign unused_in = ^{mode64, s_data[63:32]};
`endif

    assign t_last    = m ? 7'd79 : 7'd63;
    assign free      = !valid_q || m_ready;
    assign s_ready   = rst_n && (state != EXPAND) && free;
    assign accept    = s_valid && s_ready;
    assign expand_go = (state == EXPAND) && free;
    assign sum       = WW'(sig1(64'(win[14]), m)) + win[9] + WW'(sig0(64'(win[1]), m)) + win[0];
    assign nxt_word  = accept ? word_in : w_new;

    assign m_valid = valid_q;
    assign m_round = round_q;
    assign m_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    if (accept && t == 7'd15) state_nxt = EXPAND;
            EXPAND:  if (expand_go && t == t_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window, counter and output register advance together on every loaded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            data_q  <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            t       <= '0;
        end else if (accept || expand_go) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= nxt_word;
            data_q  <= nxt_word;
            round_q <= (state == IDLE) ? 7'd0 : t;
            last_q  <= expand_go && (t == t_last);
            valid_q <= 1'b1;
            if (state == IDLE)
                t <= 7'd1;
            else if (expand_go && t == t_last)
                t <= 7'd0;
            else
                t <= t + 7'd1;
        end else if (m_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule
